div_operand_sequencer: RTL



---
 rtl/div_seq_pkg.sv | 12 +
 rtl/btn_debouncer.sv | 31 +++
 rtl/div_operand_sequencer.sv | 106 ++++++++++
 3 files changed

// File: rtl/div_seq_pkg.sv
// div_seq_pkg: shared state encoding, default width and zero-divide sentinel
// for the divider operand sequencer.
package div_seq_pkg;
    localparam int DEF_W = 4;
    localparam logic [63:0] ZDIV_Q = '1;
    typedef enum logic [1:0] {
        WAIT_A  = 2'd0,
        WAIT_B  = 2'd1,
        COMPUTE = 2'd2,
        DONE    = 2'd3
    } state_t;
endpackage

// File: rtl/btn_debouncer.sv
// btn_debouncer: 2-flop synchronizer, consecutive-cycle debounce and a
// registered one-cycle pulse on each debounced rising edge.
module btn_debouncer #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic btn_raw,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic s1, s2, level, flip;
    logic [CW-1:0] cnt;
    assign flip = (s2 != level) && (cnt == LAST);
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            s1    <= btn_raw;
            s2    <= s1;
            cnt   <= (s2 == level || flip) ? '0 : cnt + 1'b1;
            level <= flip ? s2 : level;
            press <= flip & s2;
        end
    end
endmodule

// File: rtl/div_operand_sequencer.sv
// div_operand_sequencer: captures dividend/divisor on button presses, waits for
// the divider to settle and holds the result. DIV_SEQ_ZERO_CHECK_EN bypasses a zero divisor.
module div_operand_sequencer
    import div_seq_pkg::*;
#(
    parameter int W               = DEF_W,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SETTLE_CYCLES   = 2
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [W-1:0] sw,
    input  logic         btn_load,
    input  logic [W-1:0] quotient_in,
    input  logic [W-1:0] remainder_in,
    output logic [W-1:0] dividend_out,
    output logic [W-1:0] divisor_out,
    output logic [W-1:0] quotient_q,
    output logic [W-1:0] remainder_q,
    output logic         result_valid,
    output logic         div_by_zero,
    output logic [1:0]   phase
);
    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES - 1);
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [W-1:0] a_n, b_n, q_n, r_n;
    logic dbz_n, press;
    btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
        .clock(clock),
        .reset_n(reset_n),
        .btn_raw(btn_load),
        .press(press)
    );
    assign phase = state;
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        a_n     = dividend_out;
        b_n     = divisor_out;
        q_n     = quotient_q;
        r_n     = remainder_q;
        dbz_n   = div_by_zero;
        case (state)
            WAIT_A: if (press) begin
                a_n     = sw;
                state_n = WAIT_B;
            end
            WAIT_B: if (press) begin
`ifdef DIV_SEQ_ZERO_CHECK_EN
                if (sw == '0) begin
                    b_n     = '0;
                    q_n     = W'(ZDIV_Q);
                    r_n     = dividend_out;
                    dbz_n   = 1'b1;
                    state_n = DONE;
                end else
`endif
                begin
                    b_n     = sw;
                    cnt_n   = '0;
                    state_n = COMPUTE;
                end
            end
            COMPUTE: begin
                cnt_n = cnt + 1'b1;
                if (cnt == LAST) begin
                    q_n     = quotient_in;
                    r_n     = remainder_in;
                    state_n = DONE;
                end
            end
            default: if (press) begin
                a_n     = '0;
                b_n     = '0;
                q_n     = '0;
                r_n     = '0;
                dbz_n   = 1'b0;
                state_n = WAIT_A;
            end
        endcase
    end
    // without the zero check dbz_n only ever feeds back its reset value of 0
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= WAIT_A;
            cnt          <= '0;
            dividend_out <= '0;
            divisor_out  <= '0;
            quotient_q   <= '0;
            remainder_q  <= '0;
            div_by_zero  <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            dividend_out <= a_n;
            divisor_out  <= b_n;
            quotient_q   <= q_n;
            remainder_q  <= r_n;
            div_by_zero  <= dbz_n;
            result_valid <= (state_n == DONE);
        end
    end
endmodule
